// File: rtl/cfg_frame_pkg.sv
// Shared types, constants and helpers for the ID-addressed configuration frame loader.
// The CRC trailer is only present in builds that define CFG_FRAME_CRC_EN.
package cfg_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_PAY    = 3'd2,
    ST_CRC    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_SKIP   = 3'd5
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int beats(input int width, input int lanes);
    return (width + lanes - 1) / lanes;
  endfunction

  // True when id (of the given width) is the all-ones broadcast address.
  function automatic logic is_broadcast(input logic [31:0] id, input int width);
    logic [31:0] ones;
    ones = 32'd0;
    for (int i = 0; i < 32; i++) begin
      ones[i] = (i < width);
    end
    return id == ones;
  endfunction

endpackage

// File: rtl/cfg_frame_loader_crc.sv
// Combinational CRC-16-CCITT update over WIDTH data bits, bit 0 consumed first.
// Only instantiated by cfg_frame_loader when CFG_FRAME_CRC_EN is defined.
module cfg_crc16_step
  import cfg_frame_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [15:0]      crc_in,
  input  logic [WIDTH-1:0] data,
  output logic [15:0]      crc_out
);

  // Unrolled bit-serial CRC: one shift/xor stage per data bit
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (crc_out[15] ^ data[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Daisy-chained configuration frame loader: forwards every beat with one cycle of latency and
// atomically commits a matching frame's payload to cfg. Optional CRC trailer: CFG_FRAME_CRC_EN.
module cfg_frame_loader
  import cfg_frame_pkg::*;
#(
  parameter int CFG_SIZE = 800,
  parameter int LANES    = 1,
  parameter int ID_WIDTH = 3,
  parameter int ID       = 7
) (
  input  logic                clk,
  input  logic                crst_n,
  input  logic                cfg_in_start,
  input  logic [LANES-1:0]    cfg_bit_in,
  output logic                cfg_out_start,
  output logic [LANES-1:0]    cfg_bit_out,
  output logic [CFG_SIZE-1:0] cfg,
  output logic                cfg_valid,
  output logic                cfg_update,
  output logic                cfg_err
);

  localparam int HDR_BEATS = beats(ID_WIDTH, LANES);
  localparam int PAY_BEATS = beats(CFG_SIZE, LANES);
  localparam int CRC_BEATS = beats(16, LANES);
  localparam int MAX_HP    = (HDR_BEATS > PAY_BEATS) ? HDR_BEATS : PAY_BEATS;
  localparam int MAX_BEATS = (MAX_HP > CRC_BEATS) ? MAX_HP : CRC_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_BEATS - 1);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ID_WIDTH-1:0] hdr_r, hdr_s;
  logic [CFG_SIZE-1:0] shadow_r, shadow_s;
  logic [CFG_SIZE-1:0] cfg_r;
  logic                valid_r;
  logic                update_r;
  logic                out_start_r;
  logic [LANES-1:0]    bit_out_r;
  logic                commit_s;
  logic                crc_ok_s;

  function automatic logic id_hit(input logic [ID_WIDTH-1:0] h);
    return (h == ID_WIDTH'(ID)) || is_broadcast(32'(h), ID_WIDTH);
  endfunction

`ifdef CFG_FRAME_CRC_EN
  localparam int               LAST_BITS = CFG_SIZE - (PAY_BEATS - 1) * LANES;
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_BEATS - 1);

  logic [15:0] crc_r, crc_s, crc_full_s, crc_last_s;
  logic [15:0] trl_r, trl_s;
  logic        err_r;

  // The final payload beat may carry padding, so it gets a narrower CRC stage.
  cfg_crc16_step #(.WIDTH(LANES)) u_crc_full (
    .crc_in  (crc_r),
    .data    (cfg_bit_in),
    .crc_out (crc_full_s)
  );

  cfg_crc16_step #(.WIDTH(LAST_BITS)) u_crc_last (
    .crc_in  (crc_r),
    .data    (cfg_bit_in[LAST_BITS-1:0]),
    .crc_out (crc_last_s)
  );

  assign crc_ok_s = (trl_r == crc_r);
`else
  assign crc_ok_s = 1'b1;
`endif

  // Frame sequencing: beat counting, field capture and commit request
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    hdr_s    = hdr_r;
    shadow_s = shadow_r;
    commit_s = 1'b0;
`ifdef CFG_FRAME_CRC_EN
    crc_s    = crc_r;
    trl_s    = trl_r;
`endif
    if (cfg_in_start) begin
      // A start beat always opens a new frame; a pending commit still completes.
      commit_s = (state_r == ST_COMMIT);
      for (int j = 0; j < ID_WIDTH; j++) begin
        hdr_s[j] = (j < LANES) ? cfg_bit_in[j % LANES] : 1'b0;
      end
      shadow_s = '0;
`ifdef CFG_FRAME_CRC_EN
      crc_s    = CRC_INIT;
      trl_s    = 16'h0000;
`endif
      if (HDR_BEATS == 1) begin
        cnt_s   = '0;
        state_s = id_hit(hdr_s) ? ST_PAY : ST_SKIP;
      end else begin
        cnt_s   = CNT_ONE;
        state_s = ST_HDR;
      end
    end else begin
      case (state_r)
        ST_HDR: begin
          for (int j = 0; j < ID_WIDTH; j++) begin
            hdr_s[j] = (cnt_r == CNT_W'(j / LANES)) ? cfg_bit_in[j % LANES] : hdr_r[j];
          end
          if (cnt_r == HDR_LAST) begin
            cnt_s   = '0;
            state_s = id_hit(hdr_s) ? ST_PAY : ST_SKIP;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_PAY: begin
          for (int j = 0; j < CFG_SIZE; j++) begin
            shadow_s[j] = (cnt_r == CNT_W'(j / LANES)) ? cfg_bit_in[j % LANES] : shadow_r[j];
          end
          if (cnt_r == PAY_LAST) begin
            cnt_s   = '0;
`ifdef CFG_FRAME_CRC_EN
            crc_s   = crc_last_s;
            state_s = ST_CRC;
`else
            state_s = ST_COMMIT;
`endif
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
`ifdef CFG_FRAME_CRC_EN
            crc_s   = crc_full_s;
`endif
          end
        end
`ifdef CFG_FRAME_CRC_EN
        ST_CRC: begin
          for (int j = 0; j < 16; j++) begin
            trl_s[j] = (cnt_r == CNT_W'(j / LANES)) ? cfg_bit_in[j % LANES] : trl_r[j];
          end
          if (cnt_r == CRC_LAST) begin
            cnt_s   = '0;
            state_s = ST_COMMIT;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
`endif
        ST_COMMIT: begin
          commit_s = 1'b1;
          state_s  = ST_IDLE;
        end
        ST_IDLE, ST_SKIP: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Frame state, beat counter and capture registers
  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      hdr_r    <= '0;
      shadow_r <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      hdr_r    <= hdr_s;
      shadow_r <= shadow_s;
    end
  end

  // Chain passthrough and atomic commit of the shadow into the live configuration
  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      out_start_r <= 1'b0;
      bit_out_r   <= '0;
      cfg_r       <= '0;
      valid_r     <= 1'b0;
      update_r    <= 1'b0;
    end else begin
      out_start_r <= cfg_in_start;
      bit_out_r   <= cfg_bit_in;
      update_r    <= commit_s & crc_ok_s;
      if (commit_s & crc_ok_s) begin
        cfg_r   <= shadow_r;
        valid_r <= 1'b1;
      end else begin
        cfg_r   <= cfg_r;
        valid_r <= valid_r;
      end
    end
  end

`ifdef CFG_FRAME_CRC_EN
  // Running CRC, received trailer and sticky CRC-failure flag
  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      crc_r <= CRC_INIT;
      trl_r <= 16'h0000;
      err_r <= 1'b0;
    end else begin
      crc_r <= crc_s;
      trl_r <= trl_s;
      err_r <= err_r | (commit_s & ~crc_ok_s);
    end
  end

  assign cfg_err = err_r;
`else
  assign cfg_err = 1'b0;
`endif

  assign cfg_out_start = out_start_r;
  assign cfg_bit_out   = bit_out_r;
  assign cfg           = cfg_r;
  assign cfg_valid     = valid_r;
  assign cfg_update    = update_r;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: two instances (1-lane/8-bit and 4-lane/10-bit)
// driven with randomised frames and compared against a frame-level reference model.
module tb_cfg_frame_loader;

  typedef struct packed {
    logic       s;
    logic [3:0] d;
  } beat_t;

  logic       clk = 1'b0;
  logic       crst_n;
  logic       a_start, a_ostart, a_valid, a_upd, a_err;
  logic [0:0] a_in, a_obit;
  logic [7:0] a_cfg;
  logic       b_start, b_ostart, b_valid, b_upd, b_err;
  logic [3:0] b_in, b_obit;
  logic [9:0] b_cfg;

  int          checks = 0;
  int          errors = 0;
  beat_t       fq[$];
  logic [15:0] exp_cfg[2];
  logic        exp_valid[2];
  logic        exp_err[2];

  always #5 clk = ~clk;

  cfg_frame_loader #(.CFG_SIZE(8), .LANES(1), .ID_WIDTH(3), .ID(7)) u_a (
    .clk(clk), .crst_n(crst_n), .cfg_in_start(a_start), .cfg_bit_in(a_in),
    .cfg_out_start(a_ostart), .cfg_bit_out(a_obit), .cfg(a_cfg),
    .cfg_valid(a_valid), .cfg_update(a_upd), .cfg_err(a_err)
  );

  cfg_frame_loader #(.CFG_SIZE(10), .LANES(4), .ID_WIDTH(3), .ID(5)) u_b (
    .clk(clk), .crst_n(crst_n), .cfg_in_start(b_start), .cfg_bit_in(b_in),
    .cfg_out_start(b_ostart), .cfg_bit_out(b_obit), .cfg(b_cfg),
    .cfg_valid(b_valid), .cfg_update(b_upd), .cfg_err(b_err)
  );

  function automatic logic [15:0] crc16(input logic [15:0] p, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (c[15] ^ p[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] pmask(input int which);
    return (which != 0) ? 16'h03FF : 16'h00FF;
  endfunction

  // Serialise header, payload and trailer LSB-first with random padding; keep first 'limit' beats.
  task automatic add_frame(input int which, input int id, input logic [15:0] payload,
                           input bit corrupt, input int limit);
    bit          bits[$];
    int          ln, sz;
    logic [15:0] crc;
    beat_t       x;
    ln = (which != 0) ? 4 : 1;
    sz = (which != 0) ? 10 : 8;
    for (int i = 0; i < 3; i++) bits.push_back(id[i]);
    while ((bits.size() % ln) != 0) bits.push_back(1'($urandom));
    for (int i = 0; i < sz; i++) bits.push_back(payload[i]);
    while ((bits.size() % ln) != 0) bits.push_back(1'($urandom));
`ifdef CFG_FRAME_CRC_EN
    crc = crc16(payload, sz);
    if (corrupt) crc = crc ^ (16'h0001 << $urandom_range(0, 15));
    for (int i = 0; i < 16; i++) bits.push_back(crc[i]);
    while ((bits.size() % ln) != 0) bits.push_back(1'($urandom));
`else
    crc = 16'h0000;
    if (corrupt) crc = 16'h0000;
`endif
    for (int b = 0; (b * ln < bits.size()) && (b < limit); b++) begin
      x.s = (b == 0);
      x.d = 4'h0;
      for (int l = 0; l < ln; l++) x.d[l] = bits[b * ln + l];
      fq.push_back(x);
    end
  endtask

  // Reference model: outcome of one complete frame; returns number of commits (0 or 1).
  task automatic model_frame(input int which, input int id, input logic [15:0] payload,
                             input bit corrupt, output int n);
    bit hit, good;
    hit = (id == ((which != 0) ? 5 : 7)) || (id == 7);
`ifdef CFG_FRAME_CRC_EN
    good = !corrupt;
`else
    good = 1'b1;
`endif
    n = (hit && good) ? 1 : 0;
    if (hit && good) begin
      exp_cfg[which]   = payload & pmask(which);
      exp_valid[which] = 1'b1;
    end
    if (hit && !good) exp_err[which] = 1'b1;
  endtask

  // Play queued beats plus 'tail' idle beats; record update pulses, passthrough slips and cfg after last beat.
  task automatic drive(input int which, input int tail, output int uc, output int up,
                       output int pb, output logic [15:0] c0);
    int         nb;
    beat_t      x;
    logic       os, upd;
    logic [3:0] ob, m;
    nb = fq.size();
    uc = 0; up = -1; pb = 0; c0 = 16'h0000;
    m = (which != 0) ? 4'hF : 4'h1;
    for (int i = 0; i < nb + tail; i++) begin
      if (i < nb) x = fq[i];
      else begin
        x.s = 1'b0;
        x.d = 4'($urandom);
      end
      @(negedge clk);
      if (which != 0) begin b_start = x.s; b_in = x.d; end
      else begin a_start = x.s; a_in = x.d[0]; end
      @(posedge clk);
      #1;
      if (which != 0) begin os = b_ostart; ob = b_obit; upd = b_upd; end
      else begin os = a_ostart; ob = {3'b000, a_obit}; upd = a_upd; end
      if (os !== x.s || ob !== (x.d & m)) pb++;
      if (upd === 1'b1) begin uc++; up = i - nb; end
      if (i == nb) c0 = (which != 0) ? {6'd0, b_cfg} : {8'd0, a_cfg};
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    fq.delete();
  endtask

  task automatic test_reset;
    crst_n = 1'b0;
    a_start = 1'b0; a_in = 1'b0; b_start = 1'b0; b_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_cfg, a_valid, a_upd, a_err, a_ostart, a_obit} !== 13'd0) begin
      errors++;
      $display("FAIL reset_a: got cfg=%h v=%b u=%b e=%b os=%b ob=%b required all 0", a_cfg, a_valid, a_upd, a_err, a_ostart, a_obit);
    end
    checks++;
    if ({b_cfg, b_valid, b_upd, b_err, b_ostart, b_obit} !== 18'd0) begin
      errors++;
      $display("FAIL reset_b: got cfg=%h v=%b u=%b e=%b os=%b ob=%h required all 0", b_cfg, b_valid, b_upd, b_err, b_ostart, b_obit);
    end
    @(negedge clk);
    crst_n = 1'b1;
    for (int w = 0; w < 2; w++) begin
      exp_cfg[w] = 16'h0000; exp_valid[w] = 1'b0; exp_err[w] = 1'b0;
    end
  endtask

  task automatic test_basic;
    int n, uc, up, pb;
    logic [15:0] c0;
    add_frame(0, 7, 16'h00A5, 1'b0, 1000);
    model_frame(0, 7, 16'h00A5, 1'b0, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== exp_cfg[0]) begin errors++; $display("FAIL basic_cfg: got %h required %h", c0, exp_cfg[0]); end
    checks++; if (uc !== n) begin errors++; $display("FAIL basic_update_count: got %0d required %0d", uc, n); end
    checks++; if (up !== 0) begin errors++; $display("FAIL basic_update_cycle: got %0d required 0", up); end
    checks++; if (pb !== 0) begin errors++; $display("FAIL basic_passthrough: %0d slipped beats required 0", pb); end
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", a_valid); end
    checks++; if (a_err !== exp_err[0]) begin errors++; $display("FAIL basic_err: got %b required %b", a_err, exp_err[0]); end
  endtask

  task automatic test_nomatch;
    int n, uc, up, pb;
    logic [15:0] c0;
    add_frame(0, 2, 16'h003C, 1'b0, 1000);
    model_frame(0, 2, 16'h003C, 1'b0, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== exp_cfg[0]) begin errors++; $display("FAIL nomatch_cfg: got %h required %h", c0, exp_cfg[0]); end
    checks++; if (uc !== n) begin errors++; $display("FAIL nomatch_update: got %0d required %0d", uc, n); end
    checks++; if (pb !== 0) begin errors++; $display("FAIL nomatch_passthrough: %0d slipped beats required 0", pb); end
  endtask

  task automatic test_lanes4;
    int n, uc, up, pb;
    logic [15:0] c0;
    add_frame(1, 5, 16'h02F1, 1'b0, 1000);
    model_frame(1, 5, 16'h02F1, 1'b0, n);
    drive(1, 3, uc, up, pb, c0);
    checks++; if (c0 !== 16'h02F1) begin errors++; $display("FAIL lanes4_cfg: got %h required 02f1", c0); end
    checks++; if (uc !== 1 || up !== 0) begin errors++; $display("FAIL lanes4_update: got count %0d at %0d required 1 at 0", uc, up); end
    checks++; if (pb !== 0) begin errors++; $display("FAIL lanes4_passthrough: %0d slipped beats required 0", pb); end
    checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL lanes4_valid: got %b required 1", b_valid); end
  endtask

  task automatic test_abort;
    int n, uc, up, pb;
    logic [15:0] c0, junk;
    junk = 16'($urandom);
    add_frame(0, 7, junk, 1'b0, 7);
    add_frame(0, 7, 16'h000F, 1'b0, 1000);
    model_frame(0, 7, 16'h000F, 1'b0, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== 16'h000F) begin errors++; $display("FAIL abort_a_cfg: got %h required 000f", c0); end
    checks++; if (uc !== 1 || up !== 0) begin errors++; $display("FAIL abort_a_update: got count %0d at %0d required 1 at 0", uc, up); end
    junk = 16'($urandom);
    add_frame(1, 7, junk, 1'b0, 3);
    junk = 16'($urandom);
    add_frame(1, 7, junk, 1'b0, 1000);
    model_frame(1, 7, junk, 1'b0, n);
    drive(1, 3, uc, up, pb, c0);
    checks++; if (c0 !== exp_cfg[1]) begin errors++; $display("FAIL abort_b_cfg: got %h required %h", c0, exp_cfg[1]); end
    checks++; if (uc !== 1) begin errors++; $display("FAIL abort_b_update: got %0d required 1", uc); end
  endtask

  task automatic test_back_to_back;
    int n1, n2, uc, up, pb;
    logic [15:0] c0, p1, p2;
    p1 = 16'($urandom); p2 = 16'($urandom);
    add_frame(1, 5, p1, 1'b0, 1000);
    add_frame(1, 7, p2, 1'b0, 1000);
    model_frame(1, 5, p1, 1'b0, n1);
    model_frame(1, 7, p2, 1'b0, n2);
    drive(1, 3, uc, up, pb, c0);
    checks++; if (uc !== n1 + n2) begin errors++; $display("FAIL b2b_update_count: got %0d required %0d", uc, n1 + n2); end
    checks++; if (c0 !== exp_cfg[1] || up !== 0) begin errors++; $display("FAIL b2b_cfg: got %h (last update at %0d) required %h at 0", c0, up, exp_cfg[1]); end
    checks++; if (pb !== 0) begin errors++; $display("FAIL b2b_passthrough: %0d slipped beats required 0", pb); end
  endtask

`ifdef CFG_FRAME_CRC_EN
  task automatic test_crc_err;
    int n, uc, up, pb;
    logic [15:0] c0, p;
    p = 16'($urandom);
    add_frame(0, 7, p, 1'b1, 1000);
    model_frame(0, 7, p, 1'b1, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== exp_cfg[0]) begin errors++; $display("FAIL crc_bad_cfg: got %h required %h", c0, exp_cfg[0]); end
    checks++; if (uc !== 0) begin errors++; $display("FAIL crc_bad_update: got %0d required 0", uc); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL crc_bad_err: got %b required 1", a_err); end
    p = 16'($urandom);
    add_frame(0, 7, p, 1'b0, 1000);
    model_frame(0, 7, p, 1'b0, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== exp_cfg[0] || uc !== 1) begin errors++; $display("FAIL crc_good_after_bad: got %h count %0d required %h count 1", c0, uc, exp_cfg[0]); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL crc_err_sticky: got %b required 1", a_err); end
  endtask
`endif

  task automatic test_random;
    int n, uc, up, pb, w, id, eup;
    bit corrupt;
    logic [15:0] c0, p;
    for (int k = 0; k < 24; k++) begin
      w = k % 2;
      case ($urandom_range(0, 2))
        0:       id = (w != 0) ? 5 : 7;
        1:       id = 7;
        default: id = $urandom_range(0, 7);
      endcase
      p = 16'($urandom);
`ifdef CFG_FRAME_CRC_EN
      corrupt = ($urandom_range(0, 3) == 0);
`else
      corrupt = 1'b0;
`endif
      add_frame(w, id, p, corrupt, 1000);
      model_frame(w, id, p, corrupt, n);
      drive(w, 2, uc, up, pb, c0);
      eup = (n != 0) ? 0 : -1;
      checks++;
      if (c0 !== exp_cfg[w] || uc !== n || up !== eup || pb !== 0) begin
        errors++;
        $display("FAIL random_%0d: inst %0d id %0d cfg %h upd %0d at %0d slips %0d required cfg %h upd %0d at %0d slips 0",
                 k, w, id, c0, uc, up, pb, exp_cfg[w], n, eup);
      end
      checks++;
      if (((w != 0) ? b_valid : a_valid) !== exp_valid[w] || ((w != 0) ? b_err : a_err) !== exp_err[w]) begin
        errors++;
        $display("FAIL random_flags_%0d: inst %0d valid/err %b/%b required %b/%b", k, w,
                 (w != 0) ? b_valid : a_valid, (w != 0) ? b_err : a_err, exp_valid[w], exp_err[w]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, uc, up, pb;
    logic [15:0] c0;
    add_frame(0, 7, 16'h005A, 1'b0, 5);
    drive(0, 0, uc, up, pb, c0);
    #2 crst_n = 1'b0;
    #1;
    checks++;
    if ({a_cfg, a_valid, a_upd, a_err, a_ostart, a_obit} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_a: got cfg=%h v=%b u=%b e=%b os=%b ob=%b required all 0", a_cfg, a_valid, a_upd, a_err, a_ostart, a_obit);
    end
    checks++;
    if ({b_cfg, b_valid, b_upd, b_err, b_ostart, b_obit} !== 18'd0) begin
      errors++;
      $display("FAIL midreset_b: got cfg=%h v=%b u=%b e=%b os=%b ob=%h required all 0", b_cfg, b_valid, b_upd, b_err, b_ostart, b_obit);
    end
    @(negedge clk);
    crst_n = 1'b1;
    for (int w = 0; w < 2; w++) begin
      exp_cfg[w] = 16'h0000; exp_valid[w] = 1'b0; exp_err[w] = 1'b0;
    end
    add_frame(0, 7, 16'h00C3, 1'b0, 1000);
    model_frame(0, 7, 16'h00C3, 1'b0, n);
    drive(0, 3, uc, up, pb, c0);
    checks++; if (c0 !== 16'h00C3 || uc !== 1) begin errors++; $display("FAIL midreset_reload: got %h count %0d required 00c3 count 1", c0, uc); end
    checks++; if (a_valid !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL midreset_flags: valid/err %b/%b required 1/0", a_valid, a_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nomatch();
    test_lanes4();
    test_abort();
    test_back_to_back();
`ifdef CFG_FRAME_CRC_EN
    test_crc_err();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
